seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Shares the board's single 4-digit seven-segment display between two requesters, each presenting a 16-bit, four-digit BCD value. A round-robin arbiter grants ownership for a guaranteed minimum dwell of HOLD_CYCLES clocks, and a registered 16-bit digit word is driven to the downstream seven-segment scanner. The block sits between application logic and the display scanner. With no owner, all four digits show blank.

## Interface
- HOLD_CYCLES, default 100_000_000, dwell per grant term in clk cycles (1 s at 100 MHz); legal range ≥ 2.
- BLANK, default 16'hFFFF, digit word driven when no owner; nibbles > 9 render as all segments off.
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, asynchronous, active-high.
- req  input  2  req[k] = requester k wants the display; level-sensitive.
- val0  input  16  requester 0 digits {d3,d2,d1,d0}, 4 bits each.
- val1  input  16  requester 1 digits, same format.
- grant  output  2  one-hot owner, or 2'b00 when idle; registered.
- nums  output  16  digit word to the scanner; registered.
- busy  output  1  equals |grant.

## Operation
- States:
  - IDLE
  - OWN0
  - OWN1
- Round-robin pointer `last` holds the most recently granted index. Reset value 1, so requester 0 wins the first tie.
- IDLE:
  - If req is 00, stay in IDLE.
  - If exactly one request is set, grant that requester.
  - If both are set, grant index !last.
  - Any grant enters OWNk with count=0, grant=onehot(k), nums=valk, last=k.
- OWNk, non-expiry edge (count < HOLD_CYCLES-1):
  - count increments.
  - If req[k]=1, nums ← valk, so the value tracks live.
  - If req[k]=0, nums holds its frozen value. Ownership does not end early.
- OWNk, expiry edge (count == HOLD_CYCLES-1), priority order:
  - If req[!k]=1, switch directly to OWN!k: count=0, nums=val!k, last=!k. No idle gap and no blank cycle.
  - Else if req[k]=1, stay in OWNk, count=0, nums=valk.
  - Else go to IDLE: grant=00, nums=BLANK.
- A requester cannot be starved. The other side waits at most HOLD_CYCLES cycles after asserting req.
- Digit contents pass through unchecked. Non-BCD nibbles reach the scanner unchanged and render blank.
- Reset values: state=IDLE, grant=00, busy=0, nums=BLANK, count=0, last=1.
- Reset asserted mid-term takes effect immediately and asynchronously. After release, arbitration restarts from IDLE with the pointer favouring requester 0.

## Timing
- All decisions use req and val values sampled at the rising clk edge. Outputs change only on that edge, or on rst.
- Latency: req asserted before edge E in IDLE gives grant and nums valid after edge E (1 cycle).
- While owning with req[k]=1, a val change appears on nums after the next edge (1 cycle).
- Each grant term lasts exactly HOLD_CYCLES clock cycles, from the grant edge to the expiry edge.
- grant is never 2'b11. grant and nums change on the same edge.
- Counter width is $clog2(HOLD_CYCLES). The counter never wraps; it is reloaded to 0 at every expiry or grant.

## Structure
- Package seg_disp_pkg holds:
  - The state enum (IDLE, OWN0, OWN1).
  - The BLANK constant.
  - The digit-word width (16).
- One sub-module, seg_hold_timer:
  - Loadable counter with inputs `start` and `en`, output `expire`, parameter HOLD_CYCLES.
  - `expire` is high combinationally while count == HOLD_CYCLES-1.
- The top level instantiates seg_display_arbiter, then the existing four-digit scanner/decoder, connecting nums to it.

## Test plan
All scenarios use HOLD_CYCLES=4 unless noted.
- **Reset state:** Assert rst mid-simulation with no clk edges.
  - grant=00, busy=0 and nums=16'hFFFF immediately.
- **Single requester:** req=01, val0=16'h1234 held continuously.
  - grant=01 and nums=1234 one edge later.
  - The term renews every 4 cycles with no blank cycle.
  - Changing val0 to 16'h5678 appears on nums one edge later.
- **Tie and rotation:** Assert req=11 on the first edge after reset, val0=16'h0000, val1=16'h9999.
  - grant=01 for 4 cycles, then 10 for 4, then 01, and so on.
  - nums alternates 0000 and 9999 with no FFFF cycles.
- **Early drop:** Requester 0 owns with val0=16'h4321, then req0 falls at count=1.
  - nums stays 4321 until the expiry edge, then grant=00 and nums=FFFF.
- **Late contender:** Requester 0 owns and req1 rises at count=2.
  - Requester 1 is granted exactly at the expiry edge (count=3→switch), regardless of req0.
- **Reset mid-term:** Assert rst while grant=10, then release it with req=11.
  - grant=01 first (pointer reset), with 1-cycle grant latency.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Imported by the arbiter top and its hold timer.
package seg_disp_pkg;

  localparam int DW = 16;

  localparam logic [DW-1:0] BLANK_C = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/seg_hold_timer.sv
// Dwell counter for one grant term.
// start reloads zero; expire flags the last cycle of the term.
module seg_hold_timer
  import seg_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire = (cnt_q == LAST);

  // Saturate at LAST so the count can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display.
// Each grant dwells HOLD_CYCLES clocks; idle shows BLANK.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter logic [15:0] BLANK       = BLANK_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [DW-1:0] val0,
  input  logic [DW-1:0] val1,
  output logic [1:0]    grant,
  output logic [DW-1:0] nums,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [DW-1:0] nums_q, nums_d;
  logic          last_q, last_d;
  logic          start, en, expire;

  seg_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .en    (en),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    nums_d  = nums_q;
    last_d  = last_q;
    start   = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req[0] && (!req[1] || last_q)) begin
          state_d = OWN0;
          grant_d = 2'b01;
          nums_d  = val0;
          last_d  = 1'b0;
          start   = 1'b1;
        end else if (req[1]) begin
          state_d = OWN1;
          grant_d = 2'b10;
          nums_d  = val1;
          last_d  = 1'b1;
          start   = 1'b1;
        end
      end
      OWN0: begin
        if (!expire) begin
          en = 1'b1;
          if (req[0]) nums_d = val0;
        end else begin
          start = 1'b1;
          if (req[1]) begin
            state_d = OWN1;
            grant_d = 2'b10;
            nums_d  = val1;
            last_d  = 1'b1;
          end else if (req[0]) begin
            nums_d = val0;
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
            nums_d  = BLANK;
          end
        end
      end
      OWN1: begin
        if (!expire) begin
          en = 1'b1;
          if (req[1]) nums_d = val1;
        end else begin
          start = 1'b1;
          if (req[0]) begin
            state_d = OWN0;
            grant_d = 2'b01;
            nums_d  = val0;
            last_d  = 1'b0;
          end else if (req[1]) begin
            nums_d = val1;
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
            nums_d  = BLANK;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        nums_d  = BLANK;
        start   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      nums_q  <= BLANK;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      nums_q  <= nums_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign nums  = nums_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed vector bench for seg_display_arbiter.
// HOLD_CYCLES = 4 throughout.
module tb_seg_display_arbiter;

  typedef struct {
    bit          rs;
    logic [1:0]  req;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [1:0]  exp_grant;
    logic [15:0] exp_nums;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] val0 = 16'h0000;
  logic [15:0] val1 = 16'h0000;
  logic [1:0]  grant;
  logic [15:0] nums;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  seg_display_arbiter #(
    .HOLD_CYCLES(4),
    .BLANK      (16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .val0 (val0),
    .val1 (val1),
    .grant(grant),
    .nums (nums),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rs, logic [1:0] r,
                              logic [15:0] a, logic [15:0] b,
                              logic [1:0] g, logic [15:0] n);
    vec_t v;
    v.rs = rs; v.req = r; v.v0 = a; v.v1 = b;
    v.exp_grant = g; v.exp_nums = n;
    return v;
  endfunction

  task automatic check(string name, logic [1:0] g, logic [15:0] n);
    n_checks += 3;
    if (grant !== g) begin
      n_fail++;
      $display("FAIL %s grant: got %b want %b", name, grant, g);
    end
    if (nums !== n) begin
      n_fail++;
      $display("FAIL %s nums: got %h want %h", name, nums, n);
    end
    if (busy !== (|g)) begin
      n_fail++;
      $display("FAIL %s busy: got %b want %b", name, busy, |g);
    end
  endtask

  // Called just after a posedge; pulses reset without any clock edge.
  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    check("rst_async", 2'b00, 16'hFFFF);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Tie and rotation
    for (int i = 0; i < 9; i++) begin
      vec_t v;
      v = mk(i == 0, 2'b11, 16'h0000, 16'h9999,
             ((i / 4) % 2 == 0) ? 2'b01 : 2'b10,
             ((i / 4) % 2 == 0) ? 16'h0000 : 16'h9999);
      vecs.push_back(v);
    end
    // Single requester, renewal, live tracking
    vecs.push_back(mk(1, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234));
    vecs.push_back(mk(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234));
    vecs.push_back(mk(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234));
    vecs.push_back(mk(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234));
    vecs.push_back(mk(0, 2'b01, 16'h1234, 16'h0000, 2'b01, 16'h1234));
    vecs.push_back(mk(0, 2'b01, 16'h5678, 16'h0000, 2'b01, 16'h5678));
    vecs.push_back(mk(0, 2'b01, 16'h5678, 16'h0000, 2'b01, 16'h5678));
    // Early drop: frozen value until expiry, then blank
    vecs.push_back(mk(1, 2'b01, 16'h4321, 16'h0000, 2'b01, 16'h4321));
    vecs.push_back(mk(0, 2'b01, 16'h4321, 16'h0000, 2'b01, 16'h4321));
    vecs.push_back(mk(0, 2'b00, 16'h1111, 16'h0000, 2'b01, 16'h4321));
    vecs.push_back(mk(0, 2'b00, 16'h1111, 16'h0000, 2'b01, 16'h4321));
    vecs.push_back(mk(0, 2'b00, 16'h1111, 16'h0000, 2'b00, 16'hFFFF));
    vecs.push_back(mk(0, 2'b00, 16'h1111, 16'h0000, 2'b00, 16'hFFFF));
    // Late contender: switch exactly at expiry
    vecs.push_back(mk(1, 2'b01, 16'hAAAA, 16'hBBBB, 2'b01, 16'hAAAA));
    vecs.push_back(mk(0, 2'b01, 16'hAAAA, 16'hBBBB, 2'b01, 16'hAAAA));
    vecs.push_back(mk(0, 2'b11, 16'hAAAA, 16'hBBBB, 2'b01, 16'hAAAA));
    vecs.push_back(mk(0, 2'b11, 16'hAAAA, 16'hBBBB, 2'b01, 16'hAAAA));
    vecs.push_back(mk(0, 2'b10, 16'hAAAA, 16'hBBBB, 2'b10, 16'hBBBB));
    vecs.push_back(mk(0, 2'b10, 16'hAAAA, 16'hCCCC, 2'b10, 16'hCCCC));

    #12;
    check("reset_state", 2'b00, 16'hFFFF);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rs) pulse_rst();
      req  = vecs[i].req;
      val0 = vecs[i].v0;
      val1 = vecs[i].v1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_nums);
    end

    // Reset mid-term while requester 1 owns
    pulse_rst();
    req  = 2'b10;
    val1 = 16'h2222;
    @(posedge clk);
    #1;
    check("own1", 2'b10, 16'h2222);
    @(posedge clk);
    #1;
    check("own1_hold", 2'b10, 16'h2222);
    rst = 1'b1;
    #1;
    check("rst_midterm", 2'b00, 16'hFFFF);
    req  = 2'b11;
    val0 = 16'h3333;
    val1 = 16'h4444;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_tie", 2'b01, 16'h3333);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
